// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the traffic-light countdown display.
//   - PH_NONE/PH_RED/PH_YEL/PH_GRN : phase encoding used on the phase output
//   - state_t                      : display FSM state
//   - *_SEC_DEF                    : default phase durations in ticks
//   - to_bcd()                     : two-digit BCD of a constant (elaboration only)
// -----------------------------------------------------------------------------
package tl_pkg;

   localparam logic [1:0] PH_NONE = 2'd0;
   localparam logic [1:0] PH_RED  = 2'd1;
   localparam logic [1:0] PH_YEL  = 2'd2;
   localparam logic [1:0] PH_GRN  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam int RED_SEC_DEF = 10;
   localparam int YEL_SEC_DEF = 2;
   localparam int GRN_SEC_DEF = 15;

   // Only ever evaluated on parameters, so the divide never reaches hardware.
   // Result is {tens, ones}; valid for 0..99.
   function automatic logic [7:0] to_bcd(input int unsigned v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

endpackage

// File: rtl/tl_countdown_disp_if.sv
// -----------------------------------------------------------------------------
// tl_countdown_disp_if
// Bundle between the light controller side (master) and the countdown
// display (slave).
//   master drives : r, y, g, tick, clr_fault
//   slave drives  : tens, ones, blank, fault, phase
//                   (+ seg_tens, seg_ones when SEG7_EN is defined)
// Optional feature macro: SEG7_EN
// -----------------------------------------------------------------------------
interface tl_countdown_disp_if;

   logic       r;
   logic       y;
   logic       g;
   logic       tick;
   logic       clr_fault;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       blank;
   logic       fault;
   logic [1:0] phase;
`ifdef SEG7_EN
   logic [6:0] seg_tens;
   logic [6:0] seg_ones;

   modport master (output r, y, g, tick, clr_fault,
                   input  tens, ones, blank, fault, phase, seg_tens, seg_ones);
   modport slave  (input  r, y, g, tick, clr_fault,
                   output tens, ones, blank, fault, phase, seg_tens, seg_ones);
`else
   modport master (output r, y, g, tick, clr_fault,
                   input  tens, ones, blank, fault, phase);
   modport slave  (input  r, y, g, tick, clr_fault,
                   output tens, ones, blank, fault, phase);
`endif

endinterface

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD digit to 7-segment decoder, active-high segments.
//   bcd [3:0] in  : digit 0..9 (10..15 decode to all segments off)
//   seg [6:0] out : seg[6]=a, seg[5]=b, ... seg[0]=g
// Only present when SEG7_EN is defined.
// -----------------------------------------------------------------------------
`ifdef SEG7_EN
module bcd_to_seg7 (
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h00;
      case (bcd)
         4'd0:    seg = 7'h7E;
         4'd1:    seg = 7'h30;
         4'd2:    seg = 7'h6D;
         4'd3:    seg = 7'h79;
         4'd4:    seg = 7'h33;
         4'd5:    seg = 7'h5B;
         4'd6:    seg = 7'h5F;
         4'd7:    seg = 7'h70;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h7B;
         default: seg = 7'h00;
      endcase
   end

endmodule
`endif

// File: rtl/tl_countdown_disp.sv
// -----------------------------------------------------------------------------
// tl_countdown_disp
// Watches the one-hot lamp lines of the traffic-light controller, reloads the
// phase duration on each phase change and counts it down on tick as a
// two-digit BCD display. Illegal lamp patterns or sequences latch a fault
// until clr_fault.
//   clk  in : rising-edge clock
//   rst  in : asynchronous, active-low reset
//   bus     : tl_countdown_disp_if.slave
//             in  r, y, g, tick, clr_fault
//             out tens, ones, blank, fault, phase (all registered)
//             out seg_tens, seg_ones (SEG7_EN only, registered)
// Parameters RED_SEC / YEL_SEC / GRN_SEC: phase durations, 1..99 ticks.
// Optional feature macro: SEG7_EN
// -----------------------------------------------------------------------------
module tl_countdown_disp
   import tl_pkg::*;
#(
   parameter int RED_SEC = RED_SEC_DEF,
   parameter int YEL_SEC = YEL_SEC_DEF,
   parameter int GRN_SEC = GRN_SEC_DEF
) (
   input  logic                clk,
   input  logic                rst,
   tl_countdown_disp_if.slave  bus
);

   localparam logic [7:0] RED_BCD = to_bcd(RED_SEC);
   localparam logic [7:0] YEL_BCD = to_bcd(YEL_SEC);
   localparam logic [7:0] GRN_BCD = to_bcd(GRN_SEC);

   // {illegal, phase}
   function automatic logic [2:0] decode(input logic [2:0] l);
      case (l)
         3'b000:  return {1'b0, PH_NONE};
         3'b100:  return {1'b0, PH_RED};
         3'b010:  return {1'b0, PH_YEL};
         3'b001:  return {1'b0, PH_GRN};
         default: return {1'b1, PH_NONE};
      endcase
   endfunction

   function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
      return (to == PH_NONE)
          || (from == PH_NONE && to == PH_RED)
          || (from == PH_RED  && to == PH_YEL)
          || (from == PH_YEL  && to == PH_GRN)
          || (from == PH_GRN  && to == PH_RED);
   endfunction

   function automatic logic [7:0] dur_bcd(input logic [1:0] ph);
      case (ph)
         PH_RED:  return RED_BCD;
         PH_YEL:  return YEL_BCD;
         PH_GRN:  return GRN_BCD;
         default: return 8'h00;
      endcase
   endfunction

   // Saturating BCD decrement: ones borrow from tens, 00 holds.
   function automatic logic [7:0] dec_bcd(input logic [7:0] v);
      if (v[3:0] != 4'd0)      return {v[7:4], v[3:0] - 4'd1};
      else if (v[7:4] != 4'd0) return {v[7:4] - 4'd1, 4'd9};
      else                     return 8'h00;
   endfunction

   logic [2:0] lamps;
   logic [2:0] prev_q;
   logic [2:0] dec_cur;
   logic [2:0] dec_prev;
   logic       chg;
   logic       illegal_ev;

   state_t     state_q,  state_d;
   logic [7:0] digits_q, digits_d;
   logic       blank_q,  blank_d;
   logic       fault_q,  fault_d;
   logic [1:0] phase_q,  phase_d;

   assign lamps    = {bus.r, bus.y, bus.g};
   assign dec_cur  = decode(lamps);
   assign dec_prev = decode(prev_q);
   assign chg      = (lamps != prev_q);

   // A change out of an illegal pattern can only legally go dark.
   assign illegal_ev = dec_cur[2]
                     || (chg && (dec_prev[2] ? (dec_cur[1:0] != PH_NONE)
                                             : !legal_step(dec_prev[1:0], dec_cur[1:0])));

   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      blank_d  = blank_q;
      fault_d  = fault_q;
      phase_d  = phase_q;
      if (illegal_ev) begin
         // Fault outranks a simultaneous clr_fault.
         state_d  = ST_FAULT;
         digits_d = 8'h00;
         blank_d  = 1'b1;
         fault_d  = 1'b1;
         phase_d  = PH_NONE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (chg && dec_cur[1:0] == PH_RED) begin
                  state_d  = ST_RUN;
                  digits_d = RED_BCD;
                  blank_d  = 1'b0;
                  phase_d  = PH_RED;
               end
            end
            ST_RUN: begin
               if (chg) begin
                  if (dec_cur[1:0] == PH_NONE) begin
                     state_d  = ST_IDLE;
                     digits_d = 8'h00;
                     blank_d  = 1'b1;
                     phase_d  = PH_NONE;
                  end else begin
                     // Load beats a coincident tick.
                     digits_d = dur_bcd(dec_cur[1:0]);
                     blank_d  = 1'b0;
                     phase_d  = dec_cur[1:0];
                  end
               end else if (bus.tick) begin
                  digits_d = dec_bcd(digits_q);
               end
            end
            ST_FAULT: begin
               if (bus.clr_fault) begin
                  state_d  = ST_IDLE;
                  digits_d = 8'h00;
                  blank_d  = 1'b1;
                  fault_d  = 1'b0;
                  phase_d  = PH_NONE;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               digits_d = 8'h00;
               blank_d  = 1'b1;
               fault_d  = 1'b0;
               phase_d  = PH_NONE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q   <= 3'b000;
         state_q  <= ST_IDLE;
         digits_q <= 8'h00;
         blank_q  <= 1'b1;
         fault_q  <= 1'b0;
         phase_q  <= PH_NONE;
      end else begin
         prev_q   <= lamps;
         state_q  <= state_d;
         digits_q <= digits_d;
         blank_q  <= blank_d;
         fault_q  <= fault_d;
         phase_q  <= phase_d;
      end
   end

   assign bus.tens  = digits_q[7:4];
   assign bus.ones  = digits_q[3:0];
   assign bus.blank = blank_q;
   assign bus.fault = fault_q;
   assign bus.phase = phase_q;

`ifdef SEG7_EN
   logic [6:0] seg_tens_n;
   logic [6:0] seg_ones_n;
   logic [6:0] seg_tens_q;
   logic [6:0] seg_ones_q;

   // Decode the next digits so the segments register on the same edge.
   bcd_to_seg7 u_seg_tens (.bcd(digits_d[7:4]), .seg(seg_tens_n));
   bcd_to_seg7 u_seg_ones (.bcd(digits_d[3:0]), .seg(seg_ones_n));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg_tens_q <= 7'h00;
         seg_ones_q <= 7'h00;
      end else begin
         seg_tens_q <= blank_d ? 7'h00 : seg_tens_n;
         seg_ones_q <= blank_d ? 7'h00 : seg_ones_n;
      end
   end

   assign bus.seg_tens = seg_tens_q;
   assign bus.seg_ones = seg_ones_q;
`endif

endmodule
